mul_wb: RTL and testbench
=========================

# mul_wb

Writeback stage for the 64-bit iterative multiplier. It tracks the destination tag of every multiply accepted by the multiplier and pairs each tag, in order, with the result the multiplier presents in EX2. It holds up to two completed results in an in-order output buffer and drives them to the register-file writeback port under a valid/ready handshake. It also generates the multiplier's `ex2_readygo` back-pressure and handles pipeline flush.

## Interface
Parameters:
- `TAG_DEPTH`, 2: tag FIFO entries. Covers the multiplier's s1 and s2 occupancy.
- `OUT_DEPTH`, 2: output result buffer entries.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `iss_accept` in 1: the multiplier accepted an op this cycle (`mul_allowin && mul_validin`). Pushes a tag.
- `iss_rd` in 5: destination register of the accepted op.
- `iss_wen` in 1: the accepted op writes the register file.
- `iss_w32` in 1: sign-extend result bit 31 to 64 bits on writeback.
- `tag_allowin` out 1: tag FIFO not full, or a pop occurs this cycle. Issue must gate `iss_accept` with this signal.
- `mul_validout` in 1: the multiplier has a result in EX2.
- `mul_res_in` in 64: the multiplier's `mul_res_out`.
- `mul_ex2_readygo` out 1: the result is consumed this cycle. Drives the multiplier's `ex2_readygo`.
- `flush` in 1: kill all in-flight and buffered ops.
- `wb_valid` out 1: writeback data valid.
- `wb_rd` out 5: writeback destination register.
- `wb_data` out 64: writeback data.
- `wb_ready` in 1: the register-file port accepts the data this cycle.
- `tag_err` out 1: sticky flag. Set when a result arrives with the tag FIFO empty.

## Operation
- **Tag FIFO.** In-order circular FIFO of `{rd, wen, w32}` with `TAG_DEPTH` entries.
  - Push on `iss_accept`.
  - Pop on a consume event. A consume event is `mul_validout && mul_ex2_readygo`.
- **Consume event.**
  - Head tag plus `mul_res_in` form an entry.
  - Data is `w32 ? {{32{res[31]}},res[31:0]} : res`.
  - An entry with `wen==0` or `rd==0` is dropped: the tag is popped and nothing is pushed to the output buffer.
- **Output buffer.** In-order FIFO of `{rd, data}` with `OUT_DEPTH` entries.
  - Pop on `wb_valid && wb_ready`.
  - `wb_*` always reflects the head entry.
- **`mul_ex2_readygo`.** Asserted when `mul_validout && !tag_empty && (!out_full || (wb_valid && wb_ready))`.
  - A dropped entry does not need buffer space, so it is consumed whenever the tag FIFO is non-empty.
- **`tag_allowin`.** Equals `!tag_full || consume`.
  - If `iss_accept` arrives while the tag FIFO is full with no pop, the push is ignored and `tag_err` is set.
- **Missing tag.** If `mul_validout` arrives with the tag FIFO empty:
  - `mul_ex2_readygo` is held at 0.
  - `tag_err` is set and stays set until `reset`.
- **Flush.**
  - Both FIFOs are emptied at the next edge, and `wb_valid` is 0 from the next cycle.
  - Flush has priority over a same-cycle push or pop.
  - `mul_ex2_readygo` is forced to 1 while `flush && mul_validout`, so the multiplier drains its s2 result.
  - `tag_err` is not cleared by flush.
- **Simultaneous events.**
  - Push and pop in the same cycle on a full FIFO are legal: occupancy is unchanged.
  - Push and pop on an empty FIFO are legal: occupancy goes 0→0 with bypass, 0→1 without.
  - FIFO pointers wrap modulo depth.

## Timing
- **Reset.** At the first edge with `reset=1`, the following are forced to 0: `wb_valid`, `wb_rd`, `wb_data`, `tag_err`, and both FIFO pointers/counts. After reset:
  - `tag_allowin` = 1.
  - `mul_ex2_readygo` = 0.
- **Reset mid-operation.** Reset discards all entries with no writeback.
- **Latency, no bypass.** Consume at cycle N gives `wb_valid` at N+1.
- **Throughput.** One consume and one writeback per cycle, sustained.
- **`wb_ready` low.** `wb_rd` and `wb_data` hold stable while `wb_valid && !wb_ready`.

## Configuration
- **`MUL_WB_BYPASS_EN`**
  - Defined: when the output buffer is empty and a non-dropped consume occurs, `wb_valid`, `wb_rd` and `wb_data` are driven combinationally from the consume path in the same cycle.
    - If `wb_ready` is 1, the entry is not written to the buffer, giving 0-cycle latency.
    - Otherwise it is buffered as normal.
  - Undefined: all writebacks come from buffer registers with 1-cycle latency, and `wb_*` are pure register outputs.

## Test plan
- **Basic tag/result pairing.**
  - Stimulus: accept rd=5 w32=0; result `0x0000_0001_0000_0002` one cycle later, `wb_ready=1`.
  - Response: `wb_valid`, rd=5, data `0x0000_0001_0000_0002`, at N+1 (N with bypass).
- **w32 sign extension.**
  - Stimulus: w32=1, result `0x1234_5678_8000_0000`.
  - Response: `wb_data = 0xFFFF_FFFF_8000_0000`.
- **rd=0 drop.**
  - Stimulus: accept rd=0 then rd=7; two results R0, R1.
  - Response: exactly one writeback (rd=7, R1); `mul_ex2_readygo` asserted for both.
- **Back-pressure.**
  - Stimulus: `wb_ready=0`, three results for rd=1/2/3.
  - Response: two buffered; `mul_ex2_readygo=0` on the third until `wb_ready=1`; writebacks ordered 1, 2, 3.
- **Flush.**
  - Stimulus: two tags in flight, one buffered result, assert `flush` for one cycle.
  - Response: `wb_valid=0` next cycle; a pending `mul_validout` is consumed with no writeback; `tag_allowin=1`.
- **Missing-tag error.**
  - Stimulus: `mul_validout=1` with no prior accept.
  - Response: `tag_err=1` next cycle and held; `mul_ex2_readygo=0`.

Source files
------------

// File: rtl/mul_wb.sv
// Writeback stage for the 64-bit iterative multiplier: in-order tag tracking, result pairing and buffered writeback.
// Optional same-cycle writeback bypass is enabled by defining MUL_WB_BYPASS_EN.
module mul_wb #(
    parameter int TAG_DEPTH = 2,
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_accept,
    input  logic [4:0]  iss_rd,
    input  logic        iss_wen,
    input  logic        iss_w32,
    output logic        tag_allowin,
    input  logic        mul_validout,
    input  logic [63:0] mul_res_in,
    output logic        mul_ex2_readygo,
    input  logic        flush,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    input  logic        wb_ready,
    output logic        tag_err
);

    localparam int TPW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int TCW = $clog2(TAG_DEPTH + 1);
    localparam logic [TPW-1:0] TAG_LAST     = TPW'(TAG_DEPTH - 1);
    localparam logic [TCW-1:0] TAG_FULL_CNT = TCW'(TAG_DEPTH);

    function automatic logic [63:0] wb_extend(input logic [63:0] res, input logic w32);
        logic [63:0] r;
        if (w32) begin
            r = {{32{res[31]}}, res[31:0]};
        end else begin
            r = res;
        end
        return r;
    endfunction

    function automatic logic [TPW-1:0] ptr_inc(input logic [TPW-1:0] p);
        logic [TPW-1:0] r;
        if (p == TAG_LAST) begin
            r = {TPW{1'b0}};
        end else begin
            r = p + TPW'(1'b1);
        end
        return r;
    endfunction

    logic [TAG_DEPTH-1:0][4:0]  tag_rd_r;
    logic [TAG_DEPTH-1:0]       tag_wen_r;
    logic [TAG_DEPTH-1:0]       tag_w32_r;
    logic [TPW-1:0]             tag_wptr_r;
    logic [TPW-1:0]             tag_rptr_r;
    logic [TCW-1:0]             tag_cnt_r;
    logic [OUT_DEPTH-1:0]       out_val_r;
    logic [OUT_DEPTH-1:0][4:0]  out_rd_r;
    logic [OUT_DEPTH-1:0][63:0] out_data_r;
    logic                       tag_err_r;

    logic                       tag_empty_s;
    logic                       tag_full_s;
    logic [4:0]                 head_rd_s;
    logic                       head_wen_s;
    logic                       head_w32_s;
    logic                       keep_raw_s;
    logic [63:0]                cons_data_s;
    logic                       buf_pop_s;
    logic                       out_full_s;
    logic                       readygo_s;
    logic                       tag_pop_s;
    logic                       tag_push_s;
    logic                       allowin_s;
    logic                       keep_s;
    logic                       byp_take_s;
    logic                       out_push_s;
    logic                       placed_s;
    logic [OUT_DEPTH-1:0]       nxt_val_s;
    logic [OUT_DEPTH-1:0][4:0]  nxt_rd_s;
    logic [OUT_DEPTH-1:0][63:0] nxt_data_s;

    assign tag_empty_s = (tag_cnt_r == {TCW{1'b0}});
    assign tag_full_s  = (tag_cnt_r == TAG_FULL_CNT);
    assign head_rd_s   = tag_rd_r[tag_rptr_r];
    assign head_wen_s  = tag_wen_r[tag_rptr_r];
    assign head_w32_s  = tag_w32_r[tag_rptr_r];
    assign keep_raw_s  = head_wen_s && (head_rd_s != 5'd0);
    assign cons_data_s = wb_extend(mul_res_in, head_w32_s);
    assign buf_pop_s   = out_val_r[0] && wb_ready;
    assign out_full_s  = out_val_r[OUT_DEPTH-1];

    // Consume decision: flush drains unconditionally; dropped entries need no buffer space.
    assign readygo_s  = mul_validout &&
                        (flush || (!tag_empty_s && (!keep_raw_s || !out_full_s || buf_pop_s)));
    assign tag_pop_s  = readygo_s && !tag_empty_s;
    assign allowin_s  = !tag_full_s || readygo_s;
    assign tag_push_s = iss_accept && allowin_s;
    assign keep_s     = tag_pop_s && keep_raw_s && !flush;

`ifdef MUL_WB_BYPASS_EN
    logic bypass_s;
    assign bypass_s   = keep_s && !out_val_r[0];
    assign byp_take_s = bypass_s && wb_ready;
    assign wb_valid   = out_val_r[0] || bypass_s;
    assign wb_rd      = out_val_r[0] ? out_rd_r[0]   : head_rd_s;
    assign wb_data    = out_val_r[0] ? out_data_r[0] : cons_data_s;
`else
    assign byp_take_s = 1'b0;
    assign wb_valid   = out_val_r[0];
    assign wb_rd      = out_rd_r[0];
    assign wb_data    = out_data_r[0];
`endif

    assign out_push_s      = keep_s && !byp_take_s;
    assign tag_allowin     = allowin_s;
    assign mul_ex2_readygo = readygo_s;
    assign tag_err         = tag_err_r;

    // Next state of the shifting output buffer: head lives in slot 0 so wb_* come straight from registers.
    always_comb begin
        nxt_val_s  = out_val_r;
        nxt_rd_s   = out_rd_r;
        nxt_data_s = out_data_r;
        placed_s   = 1'b0;
        if (buf_pop_s) begin
            for (int i = 0; i < OUT_DEPTH - 1; i++) begin
                nxt_val_s[i]  = out_val_r[i+1];
                nxt_rd_s[i]   = out_rd_r[i+1];
                nxt_data_s[i] = out_data_r[i+1];
            end
            nxt_val_s[OUT_DEPTH-1] = 1'b0;
        end else begin
            nxt_val_s = out_val_r;
        end
        if (out_push_s) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                if (!placed_s && !nxt_val_s[i]) begin
                    nxt_val_s[i]  = 1'b1;
                    nxt_rd_s[i]   = head_rd_s;
                    nxt_data_s[i] = cons_data_s;
                    placed_s      = 1'b1;
                end else begin
                    placed_s = placed_s;
                end
            end
        end else begin
            placed_s = 1'b0;
        end
    end

    // Tag FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_rd_r   <= '0;
            tag_wen_r  <= '0;
            tag_w32_r  <= '0;
            tag_wptr_r <= {TPW{1'b0}};
            tag_rptr_r <= {TPW{1'b0}};
            tag_cnt_r  <= {TCW{1'b0}};
        end else if (flush) begin
            tag_wptr_r <= {TPW{1'b0}};
            tag_rptr_r <= {TPW{1'b0}};
            tag_cnt_r  <= {TCW{1'b0}};
        end else begin
            if (tag_push_s) begin
                tag_rd_r[tag_wptr_r]  <= iss_rd;
                tag_wen_r[tag_wptr_r] <= iss_wen;
                tag_w32_r[tag_wptr_r] <= iss_w32;
                tag_wptr_r            <= ptr_inc(tag_wptr_r);
            end
            if (tag_pop_s) begin
                tag_rptr_r <= ptr_inc(tag_rptr_r);
            end
            case ({tag_push_s, tag_pop_s})
                2'b10:   tag_cnt_r <= tag_cnt_r + TCW'(1'b1);
                2'b01:   tag_cnt_r <= tag_cnt_r - TCW'(1'b1);
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    // Output buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val_r  <= '0;
            out_rd_r   <= '0;
            out_data_r <= '0;
        end else if (flush) begin
            out_val_r <= '0;
        end else begin
            out_val_r  <= nxt_val_s;
            out_rd_r   <= nxt_rd_s;
            out_data_r <= nxt_data_s;
        end
    end

    // Sticky protocol error: result without a tag, or issue into a full tag FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_err_r <= 1'b0;
        end else if ((mul_validout && tag_empty_s && !flush) || (iss_accept && !allowin_s)) begin
            tag_err_r <= 1'b1;
        end else begin
            tag_err_r <= tag_err_r;
        end
    end

endmodule

// File: tb/tb_mul_wb.sv
// Directed self-checking bench for mul_wb (default build, no bypass).
module tb_mul_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_accept;
    logic [4:0]  iss_rd;
    logic        iss_wen;
    logic        iss_w32;
    logic        tag_allowin;
    logic        mul_validout;
    logic [63:0] mul_res_in;
    logic        mul_ex2_readygo;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_ready;
    logic        tag_err;

    int n_cmp = 0;
    int n_err = 0;

    mul_wb dut (
        .clk(clk), .reset(reset),
        .iss_accept(iss_accept), .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_w32(iss_w32),
        .tag_allowin(tag_allowin),
        .mul_validout(mul_validout), .mul_res_in(mul_res_in), .mul_ex2_readygo(mul_ex2_readygo),
        .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock edge, then let inputs change
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic accept(input logic [4:0] rd, input logic wen, input logic w32);
        iss_accept = 1'b1;
        iss_rd     = rd;
        iss_wen    = wen;
        iss_w32    = w32;
    endtask

    initial begin
        reset = 1'b1; iss_accept = 1'b0; iss_rd = 5'd0; iss_wen = 1'b0; iss_w32 = 1'b0;
        mul_validout = 1'b0; mul_res_in = 64'd0; flush = 1'b0; wb_ready = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_tag_err", {63'd0, tag_err}, 64'd0);
        chk("rst_allowin", {63'd0, tag_allowin}, 64'd1);
        chk("rst_readygo", {63'd0, mul_ex2_readygo}, 64'd0);

        // basic pairing
        accept(5'd5, 1'b1, 1'b0);
        cyc();
        iss_accept = 1'b0; mul_validout = 1'b1; mul_res_in = 64'h0000_0001_0000_0002;
        settle();
        chk("basic_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        chk("basic_no_early_wb", {63'd0, wb_valid}, 64'd0);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("basic_wb_valid", {63'd0, wb_valid}, 64'd1);
        chk("basic_wb_rd", {59'd0, wb_rd}, 64'd5);
        chk("basic_wb_data", wb_data, 64'h0000_0001_0000_0002);
        cyc();
        chk("basic_drained", {63'd0, wb_valid}, 64'd0);

        // w32 sign extension, negative and positive
        accept(5'd9, 1'b1, 1'b1);
        cyc();
        accept(5'd10, 1'b1, 1'b1);
        mul_validout = 1'b1; mul_res_in = 64'h1234_5678_8000_0000;
        cyc();
        iss_accept = 1'b0; mul_res_in = 64'hABCD_0000_7000_0001;
        settle();
        chk("w32_neg_rd", {59'd0, wb_rd}, 64'd9);
        chk("w32_neg_data", wb_data, 64'hFFFF_FFFF_8000_0000);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("w32_pos_rd", {59'd0, wb_rd}, 64'd10);
        chk("w32_pos_data", wb_data, 64'h0000_0000_7000_0001);
        cyc();

        // rd=0 drop then rd=7 writeback
        accept(5'd0, 1'b1, 1'b0);
        cyc();
        accept(5'd7, 1'b1, 1'b0);
        cyc();
        iss_accept = 1'b0;
        settle();
        chk("drop_full_allowin", {63'd0, tag_allowin}, 64'd0);
        mul_validout = 1'b1; mul_res_in = 64'h1111_2222_3333_4444;
        settle();
        chk("drop_r0_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        chk("drop_pop_allowin", {63'd0, tag_allowin}, 64'd1);
        cyc();
        mul_res_in = 64'h5555_6666_7777_8888;
        settle();
        chk("drop_no_wb", {63'd0, wb_valid}, 64'd0);
        chk("drop_r1_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("drop_r1_valid", {63'd0, wb_valid}, 64'd1);
        chk("drop_r1_rd", {59'd0, wb_rd}, 64'd7);
        chk("drop_r1_data", wb_data, 64'h5555_6666_7777_8888);
        cyc();

        // wen=0 drop
        accept(5'd4, 1'b0, 1'b0);
        cyc();
        iss_accept = 1'b0; mul_validout = 1'b1; mul_res_in = 64'h9999_9999_9999_9999;
        settle();
        chk("nowen_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("nowen_no_wb", {63'd0, wb_valid}, 64'd0);

        // back-pressure: three results with wb_ready low
        wb_ready = 1'b0;
        accept(5'd1, 1'b1, 1'b0);
        cyc();
        accept(5'd2, 1'b1, 1'b0);
        cyc();
        iss_accept = 1'b0; mul_validout = 1'b1; mul_res_in = 64'h0000_0000_0000_00A1;
        settle();
        chk("bp_a_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        accept(5'd3, 1'b1, 1'b0);
        mul_res_in = 64'h0000_0000_0000_00B2;
        settle();
        chk("bp_b_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        iss_accept = 1'b0; mul_res_in = 64'h0000_0000_0000_00C3;
        settle();
        chk("bp_c_stall", {63'd0, mul_ex2_readygo}, 64'd0);
        chk("bp_head_rd", {59'd0, wb_rd}, 64'd1);
        cyc();
        chk("bp_c_stall2", {63'd0, mul_ex2_readygo}, 64'd0);
        chk("bp_hold_rd", {59'd0, wb_rd}, 64'd1);
        chk("bp_hold_data", wb_data, 64'h0000_0000_0000_00A1);
        wb_ready = 1'b1;
        settle();
        chk("bp_c_release", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("bp_second_rd", {59'd0, wb_rd}, 64'd2);
        chk("bp_second_data", wb_data, 64'h0000_0000_0000_00B2);
        cyc();
        chk("bp_third_rd", {59'd0, wb_rd}, 64'd3);
        chk("bp_third_data", wb_data, 64'h0000_0000_0000_00C3);
        cyc();
        chk("bp_empty", {63'd0, wb_valid}, 64'd0);
        chk("bp_no_err", {63'd0, tag_err}, 64'd0);

        // flush: two tags in flight plus one buffered result
        wb_ready = 1'b0;
        accept(5'd10, 1'b1, 1'b0);
        cyc();
        accept(5'd11, 1'b1, 1'b0);
        cyc();
        accept(5'd12, 1'b1, 1'b0);
        mul_validout = 1'b1; mul_res_in = 64'h0000_0000_0000_00D4;
        cyc();
        iss_accept = 1'b0; mul_validout = 1'b0;
        settle();
        chk("fl_pre_valid", {63'd0, wb_valid}, 64'd1);
        chk("fl_pre_full", {63'd0, tag_allowin}, 64'd0);
        flush = 1'b1; mul_validout = 1'b1; mul_res_in = 64'h0000_0000_0000_00E5;
        settle();
        chk("fl_drain_readygo", {63'd0, mul_ex2_readygo}, 64'd1);
        cyc();
        flush = 1'b0;
        settle();
        chk("fl_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("fl_allowin", {63'd0, tag_allowin}, 64'd1);
        chk("fl_no_err", {63'd0, tag_err}, 64'd0);

        // missing tag: validout stays high with the tag FIFO now empty
        chk("mt_readygo", {63'd0, mul_ex2_readygo}, 64'd0);
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("mt_err_set", {63'd0, tag_err}, 64'd1);
        chk("mt_no_wb", {63'd0, wb_valid}, 64'd0);
        cyc();
        chk("mt_err_held", {63'd0, tag_err}, 64'd1);

        // reset mid-operation discards buffered entry
        accept(5'd13, 1'b1, 1'b0);
        cyc();
        iss_accept = 1'b0; mul_validout = 1'b1; mul_res_in = 64'h0000_0000_0000_00F6;
        cyc();
        mul_validout = 1'b0;
        settle();
        chk("mr_pre_valid", {63'd0, wb_valid}, 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk("mr_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("mr_wb_data", wb_data, 64'd0);
        chk("mr_tag_err", {63'd0, tag_err}, 64'd0);
        chk("mr_allowin", {63'd0, tag_allowin}, 64'd1);
        wb_ready = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
